ftq_tagged: RTL

- Parametrised successor to the single-FIFO fetch target queue.
- Circular buffer of branch-prediction metadata, indexed by a returned tag (ftq_idx).
- Branches resolve out of order by tag. Entries retire strictly in order from the head, and only once resolved.
- A mispredict squashes all younger entries in one cycle. Sits between the frontend predictor (push) and the branch unit / BHT update path (resolve, pop).

---
 rtl/ftq_tagged.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ftq_tagged.sv
// Tagged fetch target queue: circular buffer of branch-prediction metadata,
// resolved out of order by tag, retired in order from the head, truncated on mispredict.
module ftq_tagged #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_valid_i,
  input  logic              push_replay_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  output logic [IDX_W-1:0]  push_idx_o,
  input  logic              resolve_valid_i,
  input  logic [IDX_W-1:0]  resolve_idx_i,
  input  logic              resolve_mispredict_i,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [IDX_W-1:0]  head_idx_o,
  output logic              head_mispredict_o,
  input  logic              pop_i,
  output logic [IDX_W:0]    usage_o,
  output logic              overflow_o
);

  localparam int unsigned    CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  resolved_q, resolved_d;
  logic [DEPTH-1:0]  mispred_q, mispred_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [IDX_W-1:0]  res_rel;
  logic              res_live;
  logic              res_ok;
  logic              trunc;
  logic              push_block;
  logic              full;
  logic              head_vld;
  logic              pop_ok;
  logic              push_req;
  logic              push_ok;

  // Tag liveness: distance from head must fall inside the occupied window.
  assign res_rel    = resolve_idx_i - head_q;
  assign res_live   = CNT_W'(res_rel) < count_q;
  assign res_ok     = resolve_valid_i & res_live & ~resolved_q[resolve_idx_i];
  assign trunc      = res_ok & resolve_mispredict_i;
  assign push_block = resolve_valid_i & resolve_mispredict_i & res_live;

  assign full     = (count_q == DEPTH_C);
  assign head_vld = (count_q != '0) & resolved_q[head_q];
  assign pop_ok   = pop_i & head_vld & ~flush_i;
  assign push_req = push_valid_i & ~push_replay_i;

  // A full queue still accepts a push when the head retires in the same cycle.
  assign push_ready_o = (~full | pop_ok) & ~push_block & ~flush_i;
  assign push_ok      = push_req & push_ready_o;
  assign overflow_o   = push_req & full & ~pop_ok;

  assign push_idx_o        = tail_q;
  assign head_valid_o      = head_vld;
  assign head_data_o       = mem_q[head_q];
  assign head_idx_o        = head_q;
  assign head_mispredict_o = mispred_q[head_q];
  assign usage_o           = count_q;

  // Next-state for pointers, count and per-entry flags.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    resolved_d = resolved_q;
    mispred_d  = mispred_q;

    if (flush_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      resolved_d = '0;
      mispred_d  = '0;
    end else begin
      if (res_ok) begin
        resolved_d[resolve_idx_i] = 1'b1;
        mispred_d[resolve_idx_i]  = resolve_mispredict_i;
      end

      if (trunc) begin
        tail_d  = resolve_idx_i + IDX_W'(1);
        count_d = CNT_W'(res_rel) + CNT_W'(1) - CNT_W'(pop_ok);
      end else begin
        if (push_ok) begin
          resolved_d[tail_q] = 1'b0;
          mispred_d[tail_q]  = 1'b0;
          tail_d             = tail_q + IDX_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end

      if (pop_ok) begin
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      resolved_q <= resolved_d;
      mispred_q  <= mispred_d;
    end
  end

  // Payload storage needs no reset; it is only observed behind head_valid_o.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule
